// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for N_DIGITS common 7-segment digits sharing one decoder.
// Double-buffered hex value, guard gap between digits, optional leading-zero blanking.
module seven_seg_scan_ctrl #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned DWELL    = 50000,
    parameter int unsigned GUARD    = 500,
    parameter bit          LZB      = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    load,
    output logic                    load_ready,
    input  logic [N_DIGITS-1:0]     blank_mask,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     digit_en_n,
    output logic                    frame_done
);

    localparam int unsigned CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned IW      = $clog2(N_DIGITS);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0]   active_q, active_d;
    logic [4*N_DIGITS-1:0]   shadow_q, shadow_d;
    logic                    load_ready_q, load_ready_d;
    logic [6:0]              seg_q, seg_d;
    logic [N_DIGITS-1:0]     digit_en_n_q, digit_en_n_d;
    logic                    frame_done_q, frame_done_d;

    logic                    swap;
    logic                    blanked;
    logic [3:0]              nib [N_DIGITS];
    logic [N_DIGITS-1:0]     lz;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0:    hex2seg = 7'h40;
            4'h1:    hex2seg = 7'h79;
            4'h2:    hex2seg = 7'h24;
            4'h3:    hex2seg = 7'h30;
            4'h4:    hex2seg = 7'h19;
            4'h5:    hex2seg = 7'h12;
            4'h6:    hex2seg = 7'h02;
            4'h7:    hex2seg = 7'h78;
            4'h8:    hex2seg = 7'h00;
            4'h9:    hex2seg = 7'h10;
            4'hA:    hex2seg = 7'h08;
            4'hB:    hex2seg = 7'h03;
            4'hC:    hex2seg = 7'h46;
            4'hD:    hex2seg = 7'h21;
            4'hE:    hex2seg = 7'h06;
            default: hex2seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        logic run;
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        swap         = 1'b0;
        frame_done_d = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StShow;
                    idx_d   = '0;
                    cnt_d   = '0;
                    swap    = !load_ready_q;
                end
                StShow: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d      = StGap;
                        cnt_d        = '0;
                        frame_done_d = (idx_q == IDX_LAST);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = StShow;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            swap  = !load_ready_q;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Swap happens on frame entry so digit 0 of the new frame already shows new data
        active_d     = swap ? shadow_q : active_q;
        shadow_d     = shadow_q;
        load_ready_d = load_ready_q;
        if (swap) begin
            load_ready_d = 1'b1;
        end else if (load && load_ready_q) begin
            shadow_d     = value;
            load_ready_d = 1'b0;
        end

        for (int k = 0; k < int'(N_DIGITS); k++) begin
            nib[k] = active_d[4*k +: 4];
        end
        // lz[k]: nibbles k..N_DIGITS-1 are all zero
        run = 1'b1;
        for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
            run   = run & (nib[k] == 4'h0);
            lz[k] = run;
        end

        blanked      = blank_mask[idx_d] | (LZB && (idx_d != '0) && lz[idx_d]);
        seg_d        = 7'h7F;
        digit_en_n_d = '1;
        if (state_d == StShow && !blanked) begin
            seg_d               = hex2seg(nib[idx_d]);
            digit_en_n_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            load_ready_q <= 1'b1;
            seg_q        <= 7'h7F;
            digit_en_n_q <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            load_ready_q <= load_ready_d;
            seg_q        <= seg_d;
            digit_en_n_q <= digit_en_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign seg        = seg_q;
    assign digit_en_n = digit_en_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed steps plus random traffic against a
// frame-position model (digit and phase derived arithmetically from elapsed cycles).
module tb_seven_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int G     = 1;
    localparam int SLOT  = D + G;
    localparam int FRAME = N * SLOT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [15:0]   value;
    logic          load;
    logic          load_ready;
    logic [3:0]    blank_mask;
    logic [6:0]    seg;
    logic [3:0]    digit_en_n;
    logic          frame_done;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .N_DIGITS (N),
        .DWELL    (D),
        .GUARD    (G),
        .LZB      (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .value      (value),
        .load       (load),
        .load_ready (load_ready),
        .blank_mask (blank_mask),
        .seg        (seg),
        .digit_en_n (digit_en_n),
        .frame_done (frame_done)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model state: running flag, cycle position within the frame, buffers
    bit          m_run;
    int          m_t;
    logic [15:0] m_active, m_shadow;
    bit          m_pend;
    logic [6:0]  e_seg;
    logic [3:0]  e_en;
    logic        e_ready, e_fd;
    logic [6:0]  hex_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic void model_edge();
        bit   acc, blank;
        int   d, w;
        logic [15:0] upper;
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_active = '0; m_shadow = '0; m_pend = 0;
        end else begin
            acc = load && !m_pend;
            if (!enable) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
            if (m_run && m_t == 0 && m_pend) begin
                m_active = m_shadow;
                m_pend   = 0;
            end else if (acc) begin
                m_shadow = value;
                m_pend   = 1;
            end
        end
        e_ready = !m_pend;
        e_seg   = 7'h7F;
        e_en    = 4'hF;
        e_fd    = 1'b0;
        if (m_run) begin
            d     = m_t / SLOT;
            w     = m_t % SLOT;
            upper = m_active >> (4 * d);
            blank = blank_mask[d] || (d > 0 && upper == 16'h0);
            if (w < D && !blank) begin
                e_seg   = hex_seg[upper[3:0]];
                e_en[d] = 1'b0;
            end
            e_fd = (w == D) && (d == N - 1);
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("seg", {9'd0, seg}, {9'd0, e_seg});
        check("digit_en_n", {12'd0, digit_en_n}, {12'd0, e_en});
        check("load_ready", {15'd0, load_ready}, {15'd0, e_ready});
        check("frame_done", {15'd0, frame_done}, {15'd0, e_fd});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        int last_fd;
        int guard_cnt;

        // 1: reset held with enable high
        rst_n = 1'b0; enable = 1'b1; load = 1'b0; value = '0; blank_mask = '0;
        run(3);
        check("rst_seg", {9'd0, seg}, 16'h007F);
        check("rst_en", {12'd0, digit_en_n}, 16'h000F);
        check("rst_ready", {15'd0, load_ready}, 16'h0001);
        check("rst_fd", {15'd0, frame_done}, 16'h0000);
        rst_n = 1'b1;

        // 2: 1234 scan and frame period
        do_load(16'h1234);
        last_fd = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (frame_done) begin
                if (last_fd >= 0) check("fd_period", 16'(i - last_fd), 16'd20);
                last_fd = i;
            end
        end

        // 3: leading-zero blanking
        do_load(16'h0005);
        run(2 * FRAME);
        do_load(16'h0000);
        run(2 * FRAME);

        // 4: handshake mid-frame, second load dropped
        run(7);
        do_load(16'hABCD);
        check("ready_after_load", {15'd0, load_ready}, 16'h0000);
        run(2);
        do_load(16'h1111);
        run(2 * FRAME);

        // 5: blank_mask forces digit 2 dark
        blank_mask = 4'b0100;
        do_load(16'h8888);
        run(2 * FRAME);
        blank_mask = 4'b0000;

        // 6: enable drop in GAP of idx 2, re-enable, reset during SHOW
        guard_cnt = 0;
        while (!(m_run && m_t == 2 * SLOT + D) && guard_cnt < 3 * FRAME) begin
            step();
            guard_cnt++;
        end
        check("find_gap2_timeout", 16'(guard_cnt < 3 * FRAME), 16'd1);
        enable = 1'b0;
        step();
        check("idle_seg", {9'd0, seg}, 16'h007F);
        check("idle_en", {12'd0, digit_en_n}, 16'h000F);
        run(3);
        enable = 1'b1;
        run(FRAME + 3);
        do_load(16'h4321);
        rst_n = 1'b0;
        step();
        check("rst_show_en", {12'd0, digit_en_n}, 16'h000F);
        check("rst_show_ready", {15'd0, load_ready}, 16'h0001);
        rst_n = 1'b1;
        run(FRAME);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 29) != 0);
            load   = ($urandom_range(0, 5) == 0);
            value  = 16'($urandom) >> (4 * $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
            rst_n  = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
